eth_tx_frame_sched: RTL and testbench
=====================================

# eth_tx_frame_sched

Frame-level scheduler in front of the Ethernet TX AXIS buffer (32-bit write side, `s_clk_i` domain). It arbitrates round-robin between two 32-bit word sources, such as the uDMA TX channel and a control/pause-frame generator, at frame boundaries. For each granted frame it counts words against a byte length sampled at grant and generates `tlast`, `tuser` and the last-word `byte_count`. It optionally pads short frames to the Ethernet minimum.

## Interface
- `LEN_W`, 16, width of the frame-length inputs, in bytes.
- `MIN_FRAME_BYTES`, 60, padded minimum length; must be a multiple of 4 and at most 2^LEN_W-1.
- `s_clk_i`  in  1  clock.
- `s_rstn_i`  in  1  reset, asynchronous, active-low.
- `req_i`  in  2  per-source frame request; level, held until the grant.
- `len0_i`, `len1_i`  in  LEN_W  frame length in bytes; sampled on the grant edge.
- `abort_i`  in  2  per-source abort; qualifies the current source word.
- `gnt_o`  out  2  one-hot grant pulse.
- `src0_tdata_i`, `src1_tdata_i`  in  32  source words, little-endian byte order.
- `src0_tvalid_i`, `src1_tvalid_i`  in  1  source valid.
- `src0_tready_o`, `src1_tready_o`  out  1  source ready.
- `m_axis_tdata`  out  32  data to the TX buffer.
- `m_axis_byte_count`  out  2  index of the last valid byte in the word; 3 on non-last words.
- `m_axis_tvalid`, `m_axis_tuser`, `m_axis_tlast`  out  1  AXIS controls; `tuser` marks an errored frame.
- `m_axis_tready`  in  1  downstream ready (FIFO not full).
- `busy_o`  out  1  high while not in IDLE.
- `frame_done_o`  out  1  one-cycle pulse after each completed frame.
- `err_len_o`  out  1  one-cycle pulse when a zero-length frame is granted.

## Operation
- **States:** IDLE, DATA, PAD. Handshake = `tvalid & tready`.
- **IDLE, arbitration:**
  - If exactly one request is high, that source wins.
  - If both are high, the source not served last wins. The last-served pointer resets to 1, so source 0 wins first.
  - The grant latches `sel`, `len` and `src_words = ceil(len/4)`. `src_words` is computed in LEN_W+1 bits, so `len` = 2^LEN_W-1 does not overflow.
  - The pointer updates on every grant.
- **Zero length:** `len` = 0 still pulses `gnt_o`, pulses `err_len_o` in the same cycle and stays in IDLE. The pointer still advances.
- **DATA:**
  - The selected source passes combinationally to `m_axis_*`; `srcN_tready_o` = `m_axis_tready`. The unselected source's ready is 0.
  - Each handshake decrements the word counter.
  - On the last source word: `tlast` = 1 and `byte_count` = (len-1)[1:0]. Then go to IDLE, or to PAD under the padding rule.
- **Abort:** if `abort_i[sel]` is high on a handshaked word, that word carries `tlast` = 1, `tuser` = 1 and `byte_count` = 3. The frame ends in IDLE with no padding. Discarding the rest of the frame is the source's responsibility.
- **tuser:** 0 on every other word.
- **PAD:** drives `tdata` = 0 and `tvalid` = 1 and consumes no source data. Its last word has `tlast` = 1 and `byte_count` = 3.
- **frame_done_o:** pulses the cycle after the last-word handshake. It does not pulse on zero-length grants.

## Timing
- **Reset values:** all outputs 0, state IDLE, counters 0, pointer = 1.
- **Reset mid-frame:** return to IDLE immediately. No `tlast` is generated; downstream sees a truncated frame. This is accepted behaviour.
- **Grant timing:** `gnt_o` is registered. It pulses during the first DATA cycle, one cycle after `req_i` is sampled in IDLE.
- **First word:** the first word may handshake in the same cycle as the grant pulse.
- **Back-to-back frames:** exactly one IDLE cycle (`m_axis_tvalid` = 0) separates consecutive frames.
- **Zero latency:** no added latency in DATA. Upstream `tvalid` low or downstream `tready` low stalls with no state change.
- **Request removal:** a request dropped while another frame is being served is simply not seen at the next IDLE.

## Configuration
- **`ETH_TX_PAD_EN` defined:** a frame with `len` < MIN_FRAME_BYTES and no abort is padded to MIN_FRAME_BYTES.
  - The last source word has bytes above (len-1)[1:0] zeroed, with `tlast` = 0 and `byte_count` = 3.
  - PAD then emits MIN_FRAME_BYTES/4 - `src_words` words.
- **Undefined:** no PAD state; frames go out at exactly `len` bytes.

## Test plan
- **Length 10, source 0 (no pad):** words W0 W1 W2 → 3 words; `tlast` only on W2; `byte_count` 3, 3, 1; `frame_done_o` one cycle later.
- **Length 10 with `ETH_TX_PAD_EN`:** 15 words total. W2 is sent with its upper 2 bytes zeroed and `tlast` = 0. Words 4-15 are zero; word 15 has `tlast` = 1 and `byte_count` = 3.
- **Both sources requesting continuously, length 8:** grants alternate 0, 1, 0, 1. Exactly one IDLE cycle between frames.
- **Random `m_axis_tready` and source `tvalid` gaps on a 64-byte frame:** exactly 16 handshakes, data in order, no duplication.
- **`abort_i[1]` on word 3 of a 100-byte frame:** word 3 has `tlast` = 1, `tuser` = 1, `byte_count` = 3; no padding; back to IDLE.
- **len0 = 0:** `gnt_o` = 01 and `err_len_o` in the same cycle, no `tvalid`. Assert reset mid-frame: all outputs 0, then a new grant favours source 0.

Source files
------------

// File: rtl/eth_tx_frame_sched.sv
// Round-robin frame scheduler feeding the Ethernet TX AXIS buffer.
// Define ETH_TX_PAD_EN to pad short frames up to MIN_FRAME_BYTES.
module eth_tx_frame_sched #(
  parameter int LEN_W           = 16,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic             s_clk_i,
  input  logic             s_rstn_i,
  input  logic [1:0]       req_i,
  input  logic [LEN_W-1:0] len0_i,
  input  logic [LEN_W-1:0] len1_i,
  input  logic [1:0]       abort_i,
  output logic [1:0]       gnt_o,
  input  logic [31:0]      src0_tdata_i,
  input  logic [31:0]      src1_tdata_i,
  input  logic             src0_tvalid_i,
  input  logic             src1_tvalid_i,
  output logic             src0_tready_o,
  output logic             src1_tready_o,
  output logic [31:0]      m_axis_tdata,
  output logic [1:0]       m_axis_byte_count,
  output logic             m_axis_tvalid,
  output logic             m_axis_tuser,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             err_len_o
);

  localparam int CW = LEN_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAD  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            sel_q;
  logic            ptr_q;
  logic [1:0]      bc_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      gnt_q;
  logic            err_q;
  logic            done_q;

  logic            win;
  logic            win_v;
  logic [LEN_W-1:0] len_in;
  logic [CW-1:0]   words_in;
  logic [31:0]     src_d;
  logic            src_v;
  logic            abort;
  logic            is_last;
  logic            pad_go;
  logic            hs_w;

`ifdef ETH_TX_PAD_EN
  localparam logic [CW-1:0] MIN_WORDS = CW'(MIN_FRAME_BYTES / 4);
  logic [CW-1:0]   pad_q;
  logic            short_q;
  logic [31:0]     keep;
  assign pad_go = (pad_q != '0);

  always_comb begin
    keep = 32'hFFFF_FFFF;
    unique case (bc_q)
      2'd0: keep = 32'h0000_00FF;
      2'd1: keep = 32'h0000_FFFF;
      2'd2: keep = 32'h00FF_FFFF;
      default: keep = 32'hFFFF_FFFF;
    endcase
  end
`else
  assign pad_go = 1'b0;
`endif

  // Both requesting: the source not served last wins.
  always_comb begin
    win = 1'b0;
    unique case (req_i)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~ptr_q;
      default: win = 1'b0;
    endcase
  end

  // The gnt_q guard keeps a zero-length grant from re-arbitrating
  // on a request the source has not yet had a chance to drop.
  assign win_v    = (state_q == IDLE) && (req_i != 2'b00)
                    && (gnt_q == 2'b00);
  assign len_in   = win ? len1_i : len0_i;
  assign words_in = (CW'(len_in) + CW'(3)) >> 2;

  assign src_d   = sel_q ? src1_tdata_i : src0_tdata_i;
  assign src_v   = sel_q ? src1_tvalid_i : src0_tvalid_i;
  assign abort   = abort_i[sel_q];
  assign is_last = (cnt_q == CW'(1));
  assign hs_w    = m_axis_tvalid & m_axis_tready;

  always_comb begin
    state_d           = state_q;
    m_axis_tdata      = '0;
    m_axis_tvalid     = 1'b0;
    m_axis_tlast      = 1'b0;
    m_axis_tuser      = 1'b0;
    m_axis_byte_count = 2'd0;
    src0_tready_o     = 1'b0;
    src1_tready_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_v && (len_in != '0)) state_d = DATA;
      end
      DATA: begin
        m_axis_tdata      = src_d;
        m_axis_tvalid     = src_v;
        m_axis_byte_count = 2'd3;
        src0_tready_o     = ~sel_q & m_axis_tready;
        src1_tready_o     = sel_q & m_axis_tready;
        if (abort) begin
          m_axis_tlast = 1'b1;
          m_axis_tuser = 1'b1;
        end else if (is_last) begin
          m_axis_tlast = ~pad_go;
`ifdef ETH_TX_PAD_EN
          if (short_q) m_axis_tdata = src_d & keep;
          else         m_axis_byte_count = bc_q;
`else
          m_axis_byte_count = bc_q;
`endif
        end
        if (src_v && m_axis_tready && (abort || is_last))
          state_d = (!abort && pad_go) ? PAD : IDLE;
      end
`ifdef ETH_TX_PAD_EN
      PAD: begin
        m_axis_tvalid     = 1'b1;
        m_axis_byte_count = 2'd3;
        m_axis_tlast      = (pad_q == CW'(1));
        if (m_axis_tready && (pad_q == CW'(1))) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_clk_i or negedge s_rstn_i) begin
    if (!s_rstn_i) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      ptr_q   <= 1'b1;
      bc_q    <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef ETH_TX_PAD_EN
      pad_q   <= '0;
      short_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= 2'b00;
      err_q   <= 1'b0;
      done_q  <= hs_w & m_axis_tlast;
      if (win_v) begin
        gnt_q <= win ? 2'b10 : 2'b01;
        ptr_q <= win;
        sel_q <= win;
        err_q <= (len_in == '0);
        bc_q  <= len_in[1:0] - 2'd1;
        cnt_q <= words_in;
`ifdef ETH_TX_PAD_EN
        short_q <= (len_in < LEN_W'(MIN_FRAME_BYTES));
        pad_q   <= (len_in < LEN_W'(MIN_FRAME_BYTES))
                   ? (MIN_WORDS - words_in) : '0;
`endif
      end
      if ((state_q == DATA) && hs_w) cnt_q <= cnt_q - CW'(1);
`ifdef ETH_TX_PAD_EN
      if ((state_q == PAD) && hs_w) pad_q <= pad_q - CW'(1);
`endif
    end
  end

  assign gnt_o        = gnt_q;
  assign err_len_o    = err_q;
  assign frame_done_o = done_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_eth_tx_frame_sched.sv
// Directed self-checking bench for eth_tx_frame_sched.
// Honours ETH_TX_PAD_EN where frame shapes differ.
module tb_eth_tx_frame_sched;

  logic        clk;
  logic        rstn;
  logic [1:0]  req;
  logic [15:0] len0, len1;
  logic [1:0]  abort;
  logic [1:0]  gnt;
  logic [31:0] s0d, s1d;
  logic        s0v, s1v, s0r, s1r;
  logic [31:0] md;
  logic [1:0]  mbc;
  logic        mv, mu, ml, mr;
  logic        busy, done, err;

  int n_chk  = 0;
  int n_fail = 0;
  int k;

`ifdef ETH_TX_PAD_EN
  localparam int RR_LEN = 64;
`else
  localparam int RR_LEN = 8;
`endif

  eth_tx_frame_sched dut (
    .s_clk_i           (clk),
    .s_rstn_i          (rstn),
    .req_i             (req),
    .len0_i            (len0),
    .len1_i            (len1),
    .abort_i           (abort),
    .gnt_o             (gnt),
    .src0_tdata_i      (s0d),
    .src1_tdata_i      (s1d),
    .src0_tvalid_i     (s0v),
    .src1_tvalid_i     (s1v),
    .src0_tready_o     (s0r),
    .src1_tready_o     (s1r),
    .m_axis_tdata      (md),
    .m_axis_byte_count (mbc),
    .m_axis_tvalid     (mv),
    .m_axis_tuser      (mu),
    .m_axis_tlast      (ml),
    .m_axis_tready     (mr),
    .busy_o            (busy),
    .frame_done_o      (done),
    .err_len_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; req = 2'b00; len0 = '0; len1 = '0; abort = 2'b00;
    s0d = '0; s1d = '0; s0v = 1'b0; s1v = 1'b0; mr = 1'b0;
    #12;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_tvalid", mv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_tready0", s0r, 0);
    tick;
    rstn = 1'b1;
    tick;

    // Frame A: source 0, 10 bytes
    req = 2'b01; len0 = 16'd10; mr = 1'b1;
    tick;
    req = 2'b00; s0v = 1'b1; s0d = 32'h1122_3344;
    #1;
    chk("a_gnt", gnt, 2'b01);
    chk("a_busy", busy, 1);
    chk("a_w0_data", md, 32'h1122_3344);
    chk("a_w0_last", ml, 0);
    chk("a_w0_bc", mbc, 3);
    chk("a_w0_user", mu, 0);
    chk("a_rdy0", s0r, 1);
    chk("a_rdy1", s1r, 0);
    tick;
    s0d = 32'h5566_7788;
    #1;
    chk("a_w1_data", md, 32'h5566_7788);
    chk("a_w1_last", ml, 0);
    chk("a_w1_gnt", gnt, 2'b00);
    tick;
    s0d = 32'h99AA_BBCC;
    #1;
`ifdef ETH_TX_PAD_EN
    chk("a_w2_data", md, 32'h0000_BBCC);
    chk("a_w2_last", ml, 0);
    chk("a_w2_bc", mbc, 3);
    tick;
    s0v = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("a_pad_valid", mv, 1);
      chk("a_pad_data", md, 0);
      chk("a_pad_last", ml, (i == 11) ? 1 : 0);
      chk("a_pad_bc", mbc, 3);
      tick;
    end
`else
    chk("a_w2_data", md, 32'h99AA_BBCC);
    chk("a_w2_last", ml, 1);
    chk("a_w2_bc", mbc, 1);
    tick;
    s0v = 1'b0;
`endif
    #1;
    chk("a_done", done, 1);
    chk("a_idle_valid", mv, 0);
    chk("a_idle_busy", busy, 0);

    // Frame B: source 1, 100 bytes, abort on word 3
    req = 2'b10; len1 = 16'd100;
    tick;
    req = 2'b00; s1v = 1'b1; s1d = 32'hB000_0001;
    #1;
    chk("b_gnt", gnt, 2'b10);
    chk("b_w1_data", md, 32'hB000_0001);
    chk("b_w1_user", mu, 0);
    chk("b_rdy1", s1r, 1);
    chk("b_rdy0", s0r, 0);
    tick;
    s1d = 32'hB000_0002;
    #1;
    chk("b_w2_last", ml, 0);
    tick;
    s1d = 32'hB000_0003; abort = 2'b10;
    #1;
    chk("b_w3_last", ml, 1);
    chk("b_w3_user", mu, 1);
    chk("b_w3_bc", mbc, 3);
    tick;
    abort = 2'b00; s1v = 1'b0;
    #1;
    chk("b_done", done, 1);
    chk("b_busy", busy, 0);
    chk("b_valid", mv, 0);

    // Round robin: both requesting continuously
    req = 2'b11; len0 = 16'(RR_LEN); len1 = 16'(RR_LEN);
    s0v = 1'b1; s1v = 1'b1;
    s0d = 32'hC000_0000; s1d = 32'hC111_1111;
    for (int f = 0; f < 4; f++) begin
      tick;
      for (int w = 0; w < RR_LEN / 4; w++) begin
        #1;
        if (w == 0) begin
          chk("rr_gnt", gnt, (f % 2 == 0) ? 2'b01 : 2'b10);
          chk("rr_data", md,
              (f % 2 == 0) ? 32'hC000_0000 : 32'hC111_1111);
          if (f == 3) req = 2'b00;
        end
        chk("rr_last", ml, (w == RR_LEN / 4 - 1) ? 1 : 0);
        tick;
      end
      #1;
      chk("rr_gap_valid", mv, 0);
      chk("rr_gap_busy", busy, 0);
    end
    s0v = 1'b0; s1v = 1'b0;

    // 64-byte frame with random gaps on both sides
    req = 2'b01; len0 = 16'd64;
    tick;
    req = 2'b00;
    k = 0;
    for (int c = 0; c < 400 && k < 16; c++) begin
      s0v = 1'($urandom_range(0, 1));
      mr  = 1'($urandom_range(0, 1));
      s0d = 32'hD000_0000 + 32'(k);
      #1;
      if (mv && mr) begin
        chk("rnd_data", md, 32'hD000_0000 + 32'(k));
        chk("rnd_last", ml, (k == 15) ? 1 : 0);
        k++;
      end
      tick;
    end
    s0v = 1'b0; mr = 1'b1;
    #1;
    chk("rnd_count", k, 16);
    chk("rnd_done", done, 1);
    chk("rnd_busy", busy, 0);

    // Zero-length grant
    req = 2'b01; len0 = 16'd0;
    tick;
    req = 2'b00;
    #1;
    chk("z_gnt", gnt, 2'b01);
    chk("z_err", err, 1);
    chk("z_valid", mv, 0);
    chk("z_busy", busy, 0);
    tick;
    #1;
    chk("z_gnt_clr", gnt, 2'b00);
    chk("z_err_clr", err, 0);
    chk("z_no_done", done, 0);

    // Reset mid-frame, then pointer favours source 0
    req = 2'b01; len0 = 16'd40;
    tick;
    req = 2'b00; s0v = 1'b1; s0d = 32'hF000_0001;
    #1;
    chk("r_gnt", gnt, 2'b01);
    tick;
    #1;
    chk("r_busy", busy, 1);
    chk("r_valid", mv, 1);
    rstn = 1'b0;
    #1;
    chk("r_rst_valid", mv, 0);
    chk("r_rst_last", ml, 0);
    chk("r_rst_busy", busy, 0);
    chk("r_rst_rdy0", s0r, 0);
    s0v = 1'b0;
    tick;
    rstn = 1'b1;
    req = 2'b11; len0 = 16'd12; len1 = 16'd12;
    tick;
    req = 2'b00;
    #1;
    chk("r_regrant", gnt, 2'b01);

    rstn = 1'b0;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
